// File: rtl/board_keeper.sv
// Game-board store and move arbiter: validates moves, places stones, alternates players
// and scans the four line directions around the last stone for a WIN_LEN run.
module board_keeper #(
  parameter int BOARD_W   = 16,
  parameter int BOARD_H   = 16,
  parameter int CELL_BITS = 2,
  parameter int WIN_LEN   = 5,
  parameter int XW        = 4,
  parameter int YW        = 4
) (
  input  logic                                 Clck,
  input  logic                                 Reset_n,
  input  logic                                 clear,
  input  logic                                 move_valid,
  output logic                                 move_ready,
  input  logic [XW-1:0]                        move_x,
  input  logic [YW-1:0]                        move_y,
  output logic                                 resp_valid,
  output logic [1:0]                           resp_code,
  output logic [BOARD_W*BOARD_H*CELL_BITS-1:0] board,
  output logic                                 turn,
  output logic [1:0]                           gaming_status,
  output logic [$clog2(BOARD_W*BOARD_H+1)-1:0] move_count
);
  localparam int BW = BOARD_W * BOARD_H * CELL_BITS;
  localparam int CW = $clog2(BOARD_W * BOARD_H + 1);
  localparam int RW = $clog2(WIN_LEN + 1);

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} state_t;
  state_t state;

  logic [XW-1:0]        mx;
  logic [YW-1:0]        my;
  logic                 rej;
  logic [1:0]           dir;
  logic                 neg;
  logic [RW-1:0]        run;
  logic signed [XW:0]   probe_x;
  logic signed [YW:0]   probe_y;

  function automatic logic [CELL_BITS-1:0] cell_at(input logic [BW-1:0] b, input int idx);
    return b[idx*CELL_BITS +: CELL_BITS];
  endfunction

  // Direction order H, V, D, A; every direction steps +1 in x except V.
  function automatic logic signed [XW:0] step_x(input logic [1:0] d);
    logic signed [XW:0] s;
    s = (d == 2'd1) ? '0 : (XW+1)'(1);
    return s;
  endfunction

  function automatic logic signed [YW:0] step_y(input logic [1:0] d);
    logic signed [YW:0] s;
    case (d)
      2'd0:    s = '0;
      2'd3:    s = '1;
      default: s = (YW+1)'(1);
    endcase
    return s;
  endfunction

  logic [CELL_BITS-1:0] mover_cell;
  logic signed [XW:0]   mx_s, sx, sx_nx;
  logic signed [YW:0]   my_s, sy, sy_nx;
  logic                 probe_off, hit, scan_win, scan_end, acc, chk_rej;
  logic [1:0]           chk_code;
  logic [1:0]           dir_nx;
  int                   probe_idx, acc_idx, wr_idx;

  always_comb begin
    mover_cell = CELL_BITS'(turn) + CELL_BITS'(1);
    mx_s       = $signed({1'b0, mx});
    my_s       = $signed({1'b0, my});
    dir_nx     = dir + 2'd1;
    sx         = step_x(dir);
    sy         = step_y(dir);
    sx_nx      = step_x(dir_nx);
    sy_nx      = step_y(dir_nx);
    // The extra sign bit makes both -1 and W/H land outside the board.
    probe_off  = probe_x[XW] || probe_y[YW] ||
                 (int'(probe_x[XW-1:0]) >= BOARD_W) || (int'(probe_y[YW-1:0]) >= BOARD_H);
    probe_idx  = probe_off ? 0 : int'(probe_x[XW-1:0]) + int'(probe_y[YW-1:0]) * BOARD_W;
    hit        = !probe_off && (cell_at(board, probe_idx) == mover_cell);
    scan_win   = hit && (run == RW'(WIN_LEN - 1));
    scan_end   = scan_win || (!hit && neg && (dir == 2'd3));
    acc        = move_valid && move_ready;
    acc_idx    = int'(move_x) + int'(move_y) * BOARD_W;
    wr_idx     = int'(mx) + int'(my) * BOARD_W;
    chk_rej    = 1'b1;
    chk_code   = 2'b00;
    if (gaming_status != 2'b00) begin
      chk_code = 2'b11;
    end else if ((int'(move_x) >= BOARD_W) || (int'(move_y) >= BOARD_H)) begin
      chk_code = 2'b01;
    end else if (cell_at(board, acc_idx) != '0) begin
      chk_code = 2'b10;
    end else begin
      chk_rej  = 1'b0;
    end
  end

  always_ff @(posedge Clck or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      move_ready    <= 1'b0;
      resp_valid    <= 1'b0;
      resp_code     <= 2'b00;
      board         <= '0;
      turn          <= 1'b0;
      gaming_status <= 2'b00;
      move_count    <= '0;
      mx            <= '0;
      my            <= '0;
      rej           <= 1'b0;
      dir           <= 2'd0;
      neg           <= 1'b0;
      run           <= '0;
      probe_x       <= '0;
      probe_y       <= '0;
    end else if (clear) begin
      state         <= IDLE;
      move_ready    <= 1'b1;
      resp_valid    <= 1'b0;
      resp_code     <= 2'b00;
      board         <= '0;
      turn          <= 1'b0;
      gaming_status <= 2'b00;
      move_count    <= '0;
      mx            <= '0;
      my            <= '0;
      rej           <= 1'b0;
      dir           <= 2'd0;
      neg           <= 1'b0;
      run           <= '0;
      probe_x       <= '0;
      probe_y       <= '0;
    end else begin
      case (state)
        IDLE: begin
          move_ready <= 1'b1;
          resp_valid <= 1'b0;
          if (acc) begin
            // Rejects are decided here so the response pulse lands in the CHECK cycle.
            mx         <= move_x;
            my         <= move_y;
            dir        <= 2'd0;
            rej        <= chk_rej;
            move_ready <= 1'b0;
            state      <= CHECK;
            if (chk_rej) begin
              resp_valid <= 1'b1;
              resp_code  <= chk_code;
            end
          end
        end
        CHECK: begin
          resp_valid <= 1'b0;
          if (rej) begin
            move_ready <= 1'b1;
            state      <= IDLE;
          end else begin
            board[wr_idx*CELL_BITS +: CELL_BITS] <= mover_cell;
            move_count <= move_count + CW'(1);
            neg        <= 1'b0;
            run        <= RW'(1);
            probe_x    <= mx_s + sx;
            probe_y    <= my_s + sy;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (scan_end) begin
            resp_valid <= 1'b1;
            resp_code  <= 2'b00;
            state      <= DONE;
            if (scan_win) begin
              gaming_status <= turn ? 2'b10 : 2'b01;
            end else if (move_count == CW'(BOARD_W * BOARD_H)) begin
              gaming_status <= 2'b11;
            end else begin
              turn <= ~turn;
            end
          end else if (hit) begin
            run     <= run + RW'(1);
            probe_x <= neg ? probe_x - sx : probe_x + sx;
            probe_y <= neg ? probe_y - sy : probe_y + sy;
          end else if (!neg) begin
            neg     <= 1'b1;
            probe_x <= mx_s - sx;
            probe_y <= my_s - sy;
          end else begin
            dir     <= dir_nx;
            neg     <= 1'b0;
            run     <= RW'(1);
            probe_x <= mx_s + sx_nx;
            probe_y <= my_s + sy_nx;
          end
        end
        DONE: begin
          resp_valid <= 1'b0;
          move_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
